// File: rtl/hazard_pipe_ctrl_pkg.sv
// Shared types for the MIPS pipeline control slice: FSM state, the
// pipeline-register control bundle and the register-match helper.
package mips_pipe_pkg;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} pipe_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;
  } pipe_ctl_t;

  // $zero is hardwired, so a write to it never feeds a later reader.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
    return (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
  endfunction

endpackage

// File: rtl/hazard_pipe_ctrl_hazard_detect.sv
// Combinational ID-stage hazard terms: load-use and branch-operand hazards.
module hazard_detect
  import mips_pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_branch,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_dst,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dst,
  output logic       load_use,
  output logic       br_haz
);

  logic ex_match, mem_match;

  assign ex_match  = reg_match(ex_dst, id_rs, id_rt, id_uses_rt);
  assign mem_match = reg_match(mem_dst, id_rs, id_rt, id_uses_rt);

  assign load_use = ex_mem_read & ex_match;
  // Branches resolve in ID, so ALU results in EX and loads in MEM are not yet forwardable.
  assign br_haz   = id_branch & ((ex_reg_write & ex_match) | (mem_mem_read & mem_match));

endmodule

// File: rtl/hazard_pipe_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_pipe_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_UsesRt,
  input  logic              ID_Branch,
  input  logic              ID_BranchTaken,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [4:0]        EX_RegDst,
  input  logic              MEM_MemRead,
  input  logic              MEM_MemWrite,
  input  logic [4:0]        MEM_RegDst,
  input  logic              mem_ready,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              EXMEM_Write,
  output logic              MEMWB_Bubble,
  output logic              mem_req,
  output logic              mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_stall,
  output logic [PERF_W-1:0] perf_flush,
  output logic [PERF_W-1:0] perf_memwait
`endif
);

  localparam pipe_ctl_t FREEZE_CTL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};
  localparam pipe_ctl_t RESET_CTL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                       idex_bubble: 1'b1, exmem_write: 1'b0, memwb_bubble: 1'b1};

  pipe_state_t      state;
  logic [CNT_W-1:0] wcnt;
  logic             load_use, br_haz, stall, access, timeout, freeze;
  pipe_ctl_t        ctl;

  hazard_detect u_hd (
    .id_rs       (ID_rs),
    .id_rt       (ID_rt),
    .id_uses_rt  (ID_UsesRt),
    .id_branch   (ID_Branch),
    .ex_mem_read (EX_MemRead),
    .ex_reg_write(EX_RegWrite),
    .ex_dst      (EX_RegDst),
    .mem_mem_read(MEM_MemRead),
    .mem_dst     (MEM_RegDst),
    .load_use    (load_use),
    .br_haz      (br_haz)
  );

  assign stall   = load_use | br_haz;
  assign access  = MEM_MemRead | MEM_MemWrite;
  assign timeout = (state == MEM_WAIT) && !mem_ready && (wcnt == CNT_W'(TIMEOUT - 1));
  assign freeze  = (state == RUN) ? (access & ~mem_ready) : (~mem_ready & ~timeout);

  always_comb begin
    ctl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: ID_Branch & ID_BranchTaken,
            idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};
    if (stall) begin
      ctl.pc_write    = 1'b0;
      ctl.ifid_write  = 1'b0;
      ctl.ifid_flush  = 1'b0;
      ctl.idex_bubble = 1'b1;
    end
    // An abandoned access must not write back garbage, but the pipeline moves on.
    if (freeze)       ctl = FREEZE_CTL;
    else if (timeout) ctl.memwb_bubble = 1'b1;
    if (!rst_n)       ctl = RESET_CTL;
  end

  assign PC_Write     = ctl.pc_write;
  assign IFID_Write   = ctl.ifid_write;
  assign IFID_Flush   = ctl.ifid_flush;
  assign IDEX_Bubble  = ctl.idex_bubble;
  assign EXMEM_Write  = ctl.exmem_write;
  assign MEMWB_Bubble = ctl.memwb_bubble;
  assign mem_req      = rst_n & access;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        RUN: if (freeze) begin
          state <= MEM_WAIT;
          wcnt  <= CNT_W'(1);
        end
        MEM_WAIT: if (mem_ready) begin
          state <= RUN;
          wcnt  <= '0;
        end else if (timeout) begin
          state   <= RUN;
          wcnt    <= '0;
          mem_err <= 1'b1;
        end else begin
          wcnt <= wcnt + CNT_W'(1);
        end
        default: begin
          state <= RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall   <= '0;
      perf_flush   <= '0;
      perf_memwait <= '0;
    end else begin
      if (stall && !freeze && perf_stall != '1)   perf_stall   <= perf_stall + 1'b1;
      if (ctl.ifid_flush && perf_flush != '1)     perf_flush   <= perf_flush + 1'b1;
      if (state == MEM_WAIT && perf_memwait != '1) perf_memwait <= perf_memwait + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// Directed table-driven bench for hazard_pipe_ctrl plus multi-cycle sequences.
module tb_hazard_pipe_ctrl;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, br, tk, ex_mr, ex_rw;
    logic [4:0] ex_dst;
    logic       mem_mr, mem_mw;
    logic [4:0] mem_dst;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble, mem_req}
  localparam logic [6:0] O_RUN    = 7'b1100100;
  localparam logic [6:0] O_STALL  = 7'b0001100;
  localparam logic [6:0] O_FLUSH  = 7'b1110100;
  localparam logic [6:0] O_FREEZE = 7'b0000011;
  localparam logic [6:0] O_RESET  = 7'b0011010;
  localparam logic [6:0] O_TMO    = 7'b1100111;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [4:0] ID_rs, ID_rt, EX_RegDst, MEM_RegDst;
  logic       ID_UsesRt, ID_Branch, ID_BranchTaken, EX_MemRead, EX_RegWrite;
  logic       MEM_MemRead, MEM_MemWrite, mem_ready;
  logic       PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble;
  logic       mem_req, mem_err;
  logic [6:0] outs;
  int         n_tests = 0, n_fail = 0;
  vec_t       vecs[12];

  always #5 clk = ~clk;

  hazard_pipe_ctrl #(.TIMEOUT(4), .CNT_W(5), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken), .EX_MemRead(EX_MemRead),
    .EX_RegWrite(EX_RegWrite), .EX_RegDst(EX_RegDst), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_RegDst(MEM_RegDst), .mem_ready(mem_ready),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .EXMEM_Write(EXMEM_Write), .MEMWB_Bubble(MEMWB_Bubble),
    .mem_req(mem_req), .mem_err(mem_err)
  );

  assign outs = {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble, mem_req};

  function automatic vec_t mk(string name, logic [4:0] rs, logic [4:0] rt, logic uses_rt,
                              logic br, logic tk, logic ex_mr, logic ex_rw, logic [4:0] ex_dst,
                              logic mem_mr, logic mem_mw, logic [4:0] mem_dst, logic rdy,
                              logic [6:0] exp);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.br = br; v.tk = tk;
    v.ex_mr = ex_mr; v.ex_rw = ex_rw; v.ex_dst = ex_dst; v.mem_mr = mem_mr;
    v.mem_mw = mem_mw; v.mem_dst = mem_dst; v.rdy = rdy; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    ID_rs = v.rs; ID_rt = v.rt; ID_UsesRt = v.uses_rt; ID_Branch = v.br;
    ID_BranchTaken = v.tk; EX_MemRead = v.ex_mr; EX_RegWrite = v.ex_rw;
    EX_RegDst = v.ex_dst; MEM_MemRead = v.mem_mr; MEM_MemWrite = v.mem_mw;
    MEM_RegDst = v.mem_dst; mem_ready = v.rdy;
  endtask

  task automatic clear_in();
    apply(mk("", 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, O_RUN));
  endtask

  task automatic chk(input string name, input logic [6:0] exp);
    n_tests++;
    if (outs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, outs, exp);
    end
  endtask

  task automatic chk_err(input string name, input logic exp);
    n_tests++;
    if (mem_err !== exp) begin
      n_fail++;
      $display("FAIL %s: mem_err got %b expected %b", name, mem_err, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = mk("idle",        5'd0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, O_RUN);
    vecs[1]  = mk("lu_rs",       5'd8, 5'd3, 1, 0, 0, 1, 1, 5'd8, 0, 0, 5'd0, 1, O_STALL);
    vecs[2]  = mk("lu_rt",       5'd3, 5'd8, 1, 0, 0, 1, 1, 5'd8, 0, 0, 5'd0, 1, O_STALL);
    vecs[3]  = mk("lu_rt_unused",5'd3, 5'd8, 0, 0, 0, 1, 1, 5'd8, 0, 0, 5'd0, 1, O_RUN);
    vecs[4]  = mk("lu_zero",     5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 0, 0, 5'd0, 1, O_RUN);
    vecs[5]  = mk("alu_br",      5'd5, 5'd6, 1, 1, 1, 0, 1, 5'd5, 0, 0, 5'd0, 1, O_STALL);
    vecs[6]  = mk("alu_nobr",    5'd5, 5'd6, 1, 0, 0, 0, 1, 5'd5, 0, 0, 5'd0, 1, O_RUN);
    vecs[7]  = mk("memld_br",    5'd1, 5'd9, 1, 1, 0, 0, 0, 5'd0, 1, 0, 5'd9, 1, O_STALL | 7'b1);
    vecs[8]  = mk("br_taken",    5'd1, 5'd2, 1, 1, 1, 0, 0, 5'd0, 0, 0, 5'd0, 1, O_FLUSH);
    vecs[9]  = mk("br_nottaken", 5'd1, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd0, 1, O_RUN);
    vecs[10] = mk("store_ready", 5'd1, 5'd2, 1, 0, 0, 0, 0, 5'd0, 0, 1, 5'd0, 1, O_RUN | 7'b1);
    vecs[11] = mk("memalu_br",   5'd4, 5'd2, 1, 1, 0, 0, 0, 5'd0, 0, 0, 5'd4, 1, O_RUN);

    clear_in();
    #2;
    chk("reset_outs", O_RESET);
    chk_err("reset_err", 1'b0);
    #10 rst_n = 1'b1;

    foreach (vecs[i]) begin
      tick();
      apply(vecs[i]);
      #1 chk(vecs[i].name, vecs[i].exp);
    end

    // load-use: one stall, then flow
    tick(); clear_in(); EX_MemRead = 1; EX_RegWrite = 1; EX_RegDst = 5'd8; ID_rs = 5'd8;
    #1 chk("lu_seq_c1", O_STALL);
    tick(); clear_in(); ID_rs = 5'd8;
    #1 chk("lu_seq_c2", O_RUN);

    // load -> taken branch: two stalls, flush only on the third cycle
    tick(); clear_in(); ID_Branch = 1; ID_BranchTaken = 1; ID_rs = 5'd8;
    EX_MemRead = 1; EX_RegWrite = 1; EX_RegDst = 5'd8;
    #1 chk("ldbr_c1", O_STALL);
    tick(); EX_MemRead = 0; EX_RegWrite = 0; EX_RegDst = 5'd0;
    MEM_MemRead = 1; MEM_RegDst = 5'd8;
    #1 chk("ldbr_c2", O_STALL | 7'b1);
    tick(); MEM_MemRead = 0; MEM_RegDst = 5'd0;
    #1 chk("ldbr_c3", O_FLUSH);

    // memory wait: three freeze cycles then completion
    tick(); clear_in(); MEM_MemRead = 1; mem_ready = 0;
    #1 chk("mw_f1", O_FREEZE);
    tick(); #1 chk("mw_f2", O_FREEZE);
    tick(); #1 chk("mw_f3", O_FREEZE);
    tick(); mem_ready = 1;
    #1 chk("mw_done", O_RUN | 7'b1);
    tick(); clear_in();
    #1 chk("mw_after", O_RUN);
    chk_err("mw_err", 1'b0);

    // async reset in MEM_WAIT, then a full timeout proving wcnt restarted
    tick(); MEM_MemRead = 1; mem_ready = 0;
    tick(); tick();
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_outs", O_RESET);
    chk_err("rst_mid_err", 1'b0);
    #2 rst_n = 1'b1;
    #1 chk("to_w1", O_FREEZE);
    tick(); #1 chk("to_w2", O_FREEZE);
    tick(); #1 chk("to_w3", O_FREEZE);
    tick(); #1 chk("to_w4", O_TMO);
    chk_err("to_err_before", 1'b0);
    tick(); chk_err("to_err_set", 1'b1);
    chk("to_run_again", O_FREEZE);
    clear_in();
    #1 chk("to_after", O_RUN);
    tick(); tick(); chk_err("to_err_sticky", 1'b1);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1 chk_err("to_err_cleared", 1'b0);
    chk("post_reset_run", O_RUN);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_pipe_ctrl.md
Name: hazard_pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Detects load-use and branch-operand hazards at ID and squashes wrong-path fetches on taken branches.
- Freezes the pipeline while the data memory is busy, with a timeout.
- Drives write-enable and bubble/flush controls into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sits beside the hazard-free datapath; the pipeline registers consume its outputs as synchronous controls.

Parameters:
- TIMEOUT, 16: max cycles spent in MEM_WAIT before abandoning the access (≥2).
- CNT_W, 5: width of the wait counter; must hold TIMEOUT.
- PERF_W, 32: width of the performance counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ID_rs  in  5  rs field of the instruction in ID
- ID_rt  in  5  rt field of the instruction in ID
- ID_UsesRt  in  1  ID instruction reads rt (R-type, beq/bne, sw)
- ID_Branch  in  1  ID instruction is beq/bne
- ID_BranchTaken  in  1  branch comparator result in ID
- EX_MemRead  in  1  EX instruction is a load
- EX_RegWrite  in  1  EX instruction writes the register file
- EX_RegDst  in  5  EX destination register
- MEM_MemRead  in  1  MEM instruction is a load
- MEM_MemWrite  in  1  MEM instruction is a store
- MEM_RegDst  in  5  MEM destination register
- mem_ready  in  1  data memory completes the access this cycle
- PC_Write  out  1  PC update enable
- IFID_Write  out  1  IF/ID load enable
- IFID_Flush  out  1  IF/ID clear to nop
- IDEX_Bubble  out  1  ID/EX loads zero controls
- EXMEM_Write  out  1  EX/MEM load enable
- MEMWB_Bubble  out  1  MEM/WB loads RegWrite=0, MemtoReg=0
- mem_req  out  1  MEM stage access request to data memory
- mem_err  out  1  sticky timeout flag

Behaviour:
- FSM states: RUN, MEM_WAIT. There is also a wait counter wcnt[CNT_W-1:0].
- Async reset sets RUN, wcnt=0 and mem_err=0.
- While rst_n=0, the combinational outputs are forced to: PC_Write=0, IFID_Write=0, EXMEM_Write=0, IFID_Flush=1, IDEX_Bubble=1, MEMWB_Bubble=1, mem_req=0.
- Outputs are combinational from the current state and inputs, so they act in the same cycle. Registers update only on posedge clk.
- mem_req = MEM_MemRead | MEM_MemWrite in both states.
- Hazard terms (register 0 never creates a hazard):
  - match(r) = (r!=0) & ((r==ID_rs) | (ID_UsesRt & r==ID_rt)).
  - load_use = EX_MemRead & match(EX_RegDst).
  - br_haz = ID_Branch & ((EX_RegWrite & match(EX_RegDst)) | (MEM_MemRead & match(MEM_RegDst))).
  - stall = load_use | br_haz. Re-evaluation each cycle gives ALU→branch 1 stall and load→branch 2 stalls.
- Priority: memory freeze > stall > branch flush. A taken branch is ignored while stalled.
- RUN, with mem_req & !mem_ready (freeze):
  - Go to MEM_WAIT, wcnt=1.
  - PC_Write=0, IFID_Write=0, EXMEM_Write=0, IDEX_Bubble=0 (ID/EX holds), MEMWB_Bubble=1.
- RUN, no freeze, stall:
  - PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - EXMEM_Write=1, MEMWB_Bubble=0, IFID_Flush=0.
- RUN, no freeze, no stall:
  - All write enables 1.
  - IFID_Flush = ID_Branch & ID_BranchTaken; other bubbles 0.
- MEM_WAIT, on mem_ready:
  - Outputs are as in RUN without the freeze (stall/flush evaluated normally).
  - Next state RUN, wcnt=0.
- MEM_WAIT, no mem_ready, wcnt==TIMEOUT-1 (timeout):
  - Set mem_err=1, next state RUN, wcnt=0.
  - MEMWB_Bubble=1 this cycle; the access is abandoned and the pipeline advances.
- MEM_WAIT, otherwise: freeze outputs as above, wcnt+1.
- mem_err clears only on reset.
- Reset asserted mid-MEM_WAIT returns to RUN immediately.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds outputs perf_stall, perf_flush and perf_memwait, each PERF_W bits. They count cycles with stall-in-effect, taken-branch flushes, and MEM_WAIT cycles respectively.
- The counters saturate at all-ones and reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - a state enum {RUN, MEM_WAIT};
  - REG_ZERO=5'd0;
  - a struct grouping the six pipeline-register control outputs.
- One sub-module, hazard_detect: purely combinational match/load_use/br_haz logic, reused by the forwarding unit.
- The FSM, counters and output muxing stay in the top module.

Test Plan:
- Load-use: EX: lw $t0 (EX_RegDst=8, EX_MemRead=1); ID: add using rs=8 → one cycle PC_Write=0, IFID_Write=0, IDEX_Bubble=1; next cycle all enables 1.
- Load→branch: lw $8 in EX, beq rs=8 in ID → 2 consecutive stall cycles (EX then MEM match), then normal; with ID_BranchTaken=1, IFID_Flush=1 only on the third cycle.
- Register zero: EX_RegDst=0, EX_MemRead=1, ID_rs=0 → no stall.
- Memory wait: MEM_MemRead=1, mem_ready held low 3 cycles then high → 3 freeze cycles with MEMWB_Bubble=1, then RUN; mem_err stays 0.
- Timeout: TIMEOUT=4, mem_ready never rises → mem_err=1 after the 4th wait cycle, state RUN, mem_err held until rst_n pulse.
- Async reset mid-MEM_WAIT: drop rst_n between clock edges → outputs go to reset values immediately; after release, state RUN, wcnt=0.
